icache_ctrl: RTL and testbench
==============================

ICACHE_CTRL -- requirements
Module: icache_ctrl

Interface
REQ-001 Parameters, each SHALL be: DATA_WIDTH, 32, instruction/address width; CACHE_LINE_WIDTH, 128, line width (4 words); NUM_LINES, 16, direct-mapped line count (power of 2).
REQ-002 Ports SHALL be: clk  in  1  single clock; all logic on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 rd_en  in  1  fetch request strobe from the fetch queue.
REQ-005 PC_in  in  DATA_WIDTH  fetch address; bits [3:0] ignored.
REQ-006 abort  in  1  flush; kill any pending or in-flight response.
REQ-007 D_out  out  CACHE_LINE_WIDTH  fetched line; word k at bits [32k+31:32k].
REQ-008 d_out_valid  out  1  D_out valid, one-cycle pulse per delivered line.
REQ-009 mem_rd_req  out  1  refill request to backing memory.
REQ-010 mem_addr  out  DATA_WIDTH  word address of current refill beat.
REQ-011 mem_data  in  DATA_WIDTH  refill word from memory.
REQ-012 mem_data_valid  in  1  mem_data valid this cycle.
REQ-013 busy  out  1  high when not IDLE; new rd_en ignored.

Function
REQ-014 Address split SHALL be: offset [3:0], index [3+log2(NUM_LINES):4] ([7:4] default), tag = remaining upper bits.
REQ-015 Storage SHALL be per line: valid bit, tag, 128-bit data.
REQ-016 FSM states SHALL be IDLE, REFILL, RESPOND.
REQ-017 IDLE, rd_en=1, abort=0, hit (valid and tag match): D_out <= line, d_out_valid=1 at cycle N+1; stay IDLE; one hit accepted per cycle (back-to-back).
REQ-018 IDLE, rd_en=1, abort=0, miss: latch line base (PC_in & ~0xF); go REFILL; beat_cnt <= 0; d_out_valid=0 at N+1.
REQ-019 REFILL: mem_rd_req=1; mem_addr = line base + 4*beat_cnt (registered).
REQ-020 REFILL, mem_data_valid=1: word stored into slot beat_cnt; beat_cnt increments; 2-bit counter.
REQ-021 On beat 3 accepted: line data, tag, valid=1 written to array same edge; go RESPOND (or IDLE if drop flag set); mem_rd_req=0 next cycle.
REQ-022 RESPOND: d_out_valid=1 for exactly one cycle with refilled line; return IDLE; rd_en in this cycle ignored.
REQ-023 abort in IDLE same cycle as rd_en: request dropped; no d_out_valid, no refill; abort wins.
REQ-024 abort in REFILL: set drop flag; refill SHALL complete all 4 beats and update array; no d_out_valid; return to IDLE.
REQ-025 abort in RESPOND: d_out_valid suppressed; return IDLE.
REQ-026 mem_data_valid outside REFILL SHALL be ignored.
REQ-027 D_out SHALL hold last delivered line when d_out_valid=0.
REQ-028 Refill to an index already valid SHALL overwrite it (conflict eviction), no write-back.

Reset
REQ-029 rst=1 at an edge: state IDLE, all valid bits 0, beat_cnt 0, drop flag 0, D_out 0, d_out_valid 0, mem_rd_req 0, mem_addr 0, busy 0.
REQ-030 rst during REFILL: refill abandoned; mem_rd_req 0 from next cycle; partial line never marked valid.
REQ-031 Tag/data array contents need not be cleared by reset.

Verification
REQ-032 After reset, rd_en, PC_in=0x40 -> mem_addr 0x40,0x44,0x48,0x4C; return 0x11111111..0x44444444 -> next cycle d_out_valid=1, D_out=0x44444444_33333333_22222222_11111111.
REQ-033 Then rd_en, PC_in=0x48 -> hit: d_out_valid=1 next cycle, same D_out, mem_rd_req stays 0.
REQ-034 rd_en PC_in=0x140 (index 4, new tag) -> refill at 0x140; then PC_in=0x40 -> miss, refill again.
REQ-035 Miss at 0x80, abort after beat 1 -> all 4 beats consumed, no d_out_valid; then PC_in=0x80 -> hit next cycle.
REQ-036 Hits at 0x40,0x140... alternating with valid lines, rd_en every cycle -> d_out_valid every cycle, correct line each.
REQ-037 rst asserted during beat 2 -> mem_rd_req 0 next cycle; subsequent rd_en at same address -> miss.

Source files
------------

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller. Hits are answered in one cycle;
// misses refill a 4-word line from backing memory one beat at a time.
module icache_ctrl #(
    parameter int DATA_WIDTH       = 32,
    parameter int CACHE_LINE_WIDTH = 128,
    parameter int NUM_LINES        = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rd_en,
    input  logic [DATA_WIDTH-1:0]       PC_in,
    input  logic                        abort,
    output logic [CACHE_LINE_WIDTH-1:0] D_out,
    output logic                        d_out_valid,
    output logic                        mem_rd_req,
    output logic [DATA_WIDTH-1:0]       mem_addr,
    input  logic [DATA_WIDTH-1:0]       mem_data,
    input  logic                        mem_data_valid,
    output logic                        busy
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = DATA_WIDTH - 4 - IDX_W;

    typedef enum logic [1:0] {IDLE, REFILL, RESPOND} state_e;

    state_e                        state_q, state_d;
    logic [1:0]                    beat_cnt_q, beat_cnt_d;
    logic                          drop_q, drop_d;
    logic [DATA_WIDTH-1:0]         base_q, base_d;
    logic [CACHE_LINE_WIDTH-1:0]   fill_q, fill_d;
    logic [CACHE_LINE_WIDTH-1:0]   dout_q, dout_d;
    logic                          hit_vld_q, hit_vld_d;
    logic                          req_q, req_d;
    logic [DATA_WIDTH-1:0]         addr_q, addr_d;
    logic                          line_we;

    logic [NUM_LINES-1:0]          valid_q;
    logic [TAG_W-1:0]              tag_q  [NUM_LINES];
    logic [CACHE_LINE_WIDTH-1:0]   data_q [NUM_LINES];

    logic [IDX_W-1:0]              pc_idx, base_idx;
    logic [TAG_W-1:0]              pc_tag, base_tag;
    logic                          hit;
    logic [1:0]                    beat_nxt;
    logic [DATA_WIDTH-1:0]         line_mask;

    assign line_mask = {{(DATA_WIDTH-4){1'b1}}, 4'b0000};
    assign pc_idx    = PC_in[4 +: IDX_W];
    assign pc_tag    = PC_in[DATA_WIDTH-1 -: TAG_W];
    assign base_idx  = base_q[4 +: IDX_W];
    assign base_tag  = base_q[DATA_WIDTH-1 -: TAG_W];
    assign hit       = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
    assign beat_nxt  = beat_cnt_q + 2'd1;

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        drop_d     = drop_q;
        base_d     = base_q;
        fill_d     = fill_q;
        dout_d     = dout_q;
        hit_vld_d  = 1'b0;
        req_d      = req_q;
        addr_d     = addr_q;
        line_we    = 1'b0;
        case (state_q)
            IDLE: begin
                if (rd_en && !abort) begin
                    if (hit) begin
                        dout_d    = data_q[pc_idx];
                        hit_vld_d = 1'b1;
                    end else begin
                        base_d     = PC_in & line_mask;
                        addr_d     = PC_in & line_mask;
                        beat_cnt_d = 2'd0;
                        drop_d     = 1'b0;
                        req_d      = 1'b1;
                        state_d    = REFILL;
                    end
                end
            end
            REFILL: begin
                if (abort) drop_d = 1'b1;
                if (mem_data_valid) begin
                    fill_d[DATA_WIDTH*int'(beat_cnt_q) +: DATA_WIDTH] = mem_data;
                    beat_cnt_d = beat_nxt;
                    addr_d     = base_q | DATA_WIDTH'({beat_nxt, 2'b00});
                    if (beat_cnt_q == 2'd3) begin
                        // A dropped refill still fills the array so the work is not wasted.
                        line_we = 1'b1;
                        req_d   = 1'b0;
                        addr_d  = base_q;
                        drop_d  = 1'b0;
                        state_d = (drop_q || abort) ? IDLE : RESPOND;
                    end
                end
            end
            RESPOND: begin
                if (!abort) dout_d = fill_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            beat_cnt_q <= 2'd0;
            drop_q     <= 1'b0;
            base_q     <= '0;
            fill_q     <= '0;
            dout_q     <= '0;
            hit_vld_q  <= 1'b0;
            req_q      <= 1'b0;
            addr_q     <= '0;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            drop_q     <= drop_d;
            base_q     <= base_d;
            fill_q     <= fill_d;
            dout_q     <= dout_d;
            hit_vld_q  <= hit_vld_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            if (line_we) valid_q[base_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_q[base_idx]  <= base_tag;
            data_q[base_idx] <= fill_d;
        end
    end

    // The refilled line is shown directly in RESPOND so abort can still veto it.
    assign d_out_valid = hit_vld_q || ((state_q == RESPOND) && !abort);
    assign D_out       = ((state_q == RESPOND) && !abort) ? fill_q : dout_q;
    assign mem_rd_req  = req_q;
    assign mem_addr    = addr_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl: refills, hits, aborts in each state and
// reset in the middle of a refill, each checked against hand-computed values.
module tb_icache_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         rd_en;
    logic [31:0]  PC_in;
    logic         abort;
    logic [127:0] D_out;
    logic         d_out_valid;
    logic         mem_rd_req;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_data;
    logic         mem_data_valid;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [127:0] L40A = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] L140 = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
    localparam logic [127:0] L40B = 128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0;
    localparam logic [127:0] L80  = 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0;
    localparam logic [127:0] L300 = 128'hD3D3D3D3_D2D2D2D2_D1D1D1D1_D0D0D0D0;
    localparam logic [127:0] L500 = 128'hE3E3E3E3_E2E2E2E2_E1E1E1E1_E0E0E0E0;

    icache_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .rd_en          (rd_en),
        .PC_in          (PC_in),
        .abort          (abort),
        .D_out          (D_out),
        .d_out_valid    (d_out_valid),
        .mem_rd_req     (mem_rd_req),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .mem_data_valid (mem_data_valid),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Miss, 4 beats (with one idle gap before beat 2), then the response cycle.
    task automatic do_miss(input string tag, input logic [31:0] addr, input logic [127:0] line,
                           input int abort_beat, input bit abort_resp, input bit rd_in_resp,
                           inout logic [127:0] last_line);
        logic [31:0]  base;
        logic [127:0] held;
        base  = addr & 32'hFFFF_FFF0;
        rd_en = 1'b1;
        PC_in = addr;
        tick();
        rd_en = 1'b0;
        check({tag, " miss_valid"}, d_out_valid, 0);
        check({tag, " miss_req"}, mem_rd_req, 1);
        check({tag, " miss_busy"}, busy, 1);
        for (int k = 0; k < 4; k++) begin
            if (k == 2) begin
                tick();
                check({tag, " gap_addr"}, mem_addr, base + 32'd8);
            end
            check({tag, $sformatf(" beat%0d_addr", k)}, mem_addr, base + 32'(4 * k));
            check({tag, $sformatf(" beat%0d_req", k)}, mem_rd_req, 1);
            mem_data_valid = 1'b1;
            mem_data       = line[32*k +: 32];
            abort          = (k == abort_beat);
            tick();
            mem_data_valid = 1'b0;
            abort          = 1'b0;
        end
        check({tag, " req_drop"}, mem_rd_req, 0);
        if (abort_beat >= 0) begin
            check({tag, " drop_valid"}, d_out_valid, 0);
            check({tag, " drop_busy"}, busy, 0);
            check({tag, " drop_dout"}, D_out, last_line);
        end else begin
            abort = abort_resp;
            rd_en = rd_in_resp;
            PC_in = 32'h0000_0700;
            #1;
            held = abort_resp ? last_line : line;
            check({tag, " resp_valid"}, d_out_valid, !abort_resp);
            check({tag, " resp_dout"}, D_out, held);
            check({tag, " resp_busy"}, busy, 1);
            tick();
            abort = 1'b0;
            rd_en = 1'b0;
            check({tag, " post_valid"}, d_out_valid, 0);
            check({tag, " post_busy"}, busy, 0);
            check({tag, " post_req"}, mem_rd_req, 0);
            check({tag, " post_dout"}, D_out, held);
            last_line = held;
        end
    endtask

    task automatic do_hit(input string tag, input logic [31:0] addr, input logic [127:0] line);
        rd_en = 1'b1;
        PC_in = addr;
        tick();
        rd_en = 1'b0;
        check({tag, " hit_valid"}, d_out_valid, 1);
        check({tag, " hit_dout"}, D_out, line);
        check({tag, " hit_req"}, mem_rd_req, 0);
        check({tag, " hit_busy"}, busy, 0);
    endtask

    initial begin
        logic [127:0] last_line;
        logic [31:0]  b2b_addr [4];
        logic [127:0] b2b_line [4];

        rst = 1'b1; rd_en = 1'b0; PC_in = '0; abort = 1'b0;
        mem_data = '0; mem_data_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst valid", d_out_valid, 0);
        check("rst dout", D_out, 0);
        check("rst req", mem_rd_req, 0);
        check("rst addr", mem_addr, 0);
        check("rst busy", busy, 0);
        last_line = '0;

        do_miss("m40", 32'h40, L40A, -1, 1'b0, 1'b0, last_line);
        do_hit("h48", 32'h48, L40A);
        last_line = L40A;

        // Same index, different tag: evicts 0x40; rd_en in RESPOND must be ignored.
        do_miss("m140", 32'h140, L140, -1, 1'b0, 1'b1, last_line);
        do_miss("m40b", 32'h44, L40B, -1, 1'b0, 1'b0, last_line);

        do_miss("m80abort", 32'h80, L80, 1, 1'b0, 1'b0, last_line);
        do_hit("h80", 32'h80, L80);
        last_line = L80;

        b2b_addr = '{32'h40, 32'h84, 32'h4C, 32'h88};
        b2b_line = '{L40B, L80, L40B, L80};
        rd_en = 1'b1;
        PC_in = b2b_addr[0];
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("b2b%0d valid", i), d_out_valid, 1);
            check($sformatf("b2b%0d dout", i), D_out, b2b_line[i]);
            if (i < 3) PC_in = b2b_addr[i+1];
            else rd_en = 1'b0;
        end
        tick();
        check("b2b end valid", d_out_valid, 0);
        last_line = L80;

        // abort together with rd_en in IDLE: both a miss and a hit get dropped.
        rd_en = 1'b1; abort = 1'b1; PC_in = 32'h200;
        tick();
        check("idle_abort miss req", mem_rd_req, 0);
        check("idle_abort miss busy", busy, 0);
        check("idle_abort miss valid", d_out_valid, 0);
        PC_in = 32'h40;
        tick();
        rd_en = 1'b0; abort = 1'b0;
        check("idle_abort hit valid", d_out_valid, 0);
        check("idle_abort hit dout", D_out, last_line);

        do_miss("m300respabort", 32'h300, L300, -1, 1'b1, 1'b0, last_line);
        do_hit("h300", 32'h30C, L300);
        last_line = L300;

        mem_data_valid = 1'b1; mem_data = 32'hDEAD_BEEF;
        tick();
        mem_data_valid = 1'b0;
        check("stray_mdv busy", busy, 0);
        check("stray_mdv req", mem_rd_req, 0);
        do_hit("h300b", 32'h300, L300);

        // Reset while beat 2 is being accepted.
        rd_en = 1'b1; PC_in = 32'h500;
        tick();
        rd_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mem_data_valid = 1'b1;
            mem_data       = L500[32*k +: 32];
            rst            = (k == 2);
            tick();
        end
        mem_data_valid = 1'b0; rst = 1'b0;
        check("midrst req", mem_rd_req, 0);
        check("midrst busy", busy, 0);
        check("midrst valid", d_out_valid, 0);
        check("midrst dout", D_out, 0);
        last_line = '0;
        do_miss("m500", 32'h500, L500, -1, 1'b0, 1'b0, last_line);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
